// File: rtl/join_fflop.sv
// Two-stream join: each 8-bit input is buffered in its own FIFO, matched heads are
// paired into {A, B} and emitted through a registered main+skid output stage.

module join_fflop_fifo #(
  parameter int Size  = 8,
  parameter int Depth = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [Size-1:0] data_i,
  output logic [Size-1:0] data_o,
  output logic            full_o,
  output logic            empty_o
);
  localparam int PW = $clog2(Depth);
  localparam int CW = $clog2(Depth + 1);

  logic [Size-1:0] mem_q [Depth];
  logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  assign full_o  = (cnt_q == CW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rd_q];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_i) wr_d = wr_q + PW'(1);
    if (pop_i)  rd_d = rd_q + PW'(1);
    if (push_i && !pop_i)      cnt_d = cnt_q + CW'(1);
    else if (!push_i && pop_i) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset; occupancy alone says which entries are live.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= data_i;
  end
endmodule

module join_fflop #(
  parameter int Size  = 8,
  parameter int Depth = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [Size-1:0]   inp_a,
  input  logic              inp_aValid,
  output logic              inp_aRetry,
  input  logic [Size-1:0]   inp_b,
  input  logic              inp_bValid,
  output logic              inp_bRetry,
  output logic [2*Size-1:0] out,
  output logic              outValid,
  input  logic              outRetry,
  output logic [15:0]       pair_count
);
  logic              push_a, push_b, empty_a, empty_b, full_a, full_b;
  logic [Size-1:0]   head_a, head_b;
  logic              fire, pop;
  logic [2*Size-1:0] main_q, main_d, skid_q, skid_d;
  logic [1:0]        occ_q, occ_d;
  logic [15:0]       pair_q, pair_d;

  assign push_a = inp_aValid && !full_a;
  assign push_b = inp_bValid && !full_b;

  join_fflop_fifo #(.Size(Size), .Depth(Depth)) u_fifo_a (
    .clk(clk), .reset(reset), .push_i(push_a), .pop_i(fire), .data_i(inp_a),
    .data_o(head_a), .full_o(full_a), .empty_o(empty_a)
  );

  join_fflop_fifo #(.Size(Size), .Depth(Depth)) u_fifo_b (
    .clk(clk), .reset(reset), .push_i(push_b), .pop_i(fire), .data_i(inp_b),
    .data_o(head_b), .full_o(full_b), .empty_o(empty_b)
  );

  assign fire = !empty_a && !empty_b && (occ_q != 2'd2);
  assign pop  = (occ_q != 2'd0) && !outRetry;

  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    occ_d  = occ_q;
    pair_d = pair_q;
    if (pop) begin
      pair_d = pair_q + 16'd1;
      if (occ_q == 2'd2) main_d = skid_q;
    end
    // A new pair goes to main only when main is (or is becoming) free with skid empty.
    if (fire) begin
      if (occ_q == 2'd0 || (occ_q == 2'd1 && pop)) main_d = {head_a, head_b};
      else                                         skid_d = {head_a, head_b};
    end
    case ({fire, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_q <= '0;
      skid_q <= '0;
      occ_q  <= '0;
      pair_q <= '0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
      occ_q  <= occ_d;
      pair_q <= pair_d;
    end
  end

  assign out        = main_q;
  assign outValid   = (occ_q != 2'd0);
  assign inp_aRetry = full_a;
  assign inp_bRetry = full_b;
  assign pair_count = pair_q;
endmodule

// File: tb/tb_join_fflop.sv
// Randomized + directed bench for join_fflop; a queue-based model pairs the i-th
// accepted A with the i-th accepted B and a negedge monitor scores every output pop.

module tb_join_fflop;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  inp_a = '0, inp_b = '0;
  logic        inp_aValid = 1'b0, inp_bValid = 1'b0;
  logic        inp_aRetry, inp_bRetry;
  logic [15:0] out;
  logic        outValid;
  logic        outRetry = 1'b0;
  logic [15:0] pair_count;

  int checks = 0;
  int errors = 0;

  logic [7:0]  qa[$], qb[$];
  logic [15:0] exp_q[$];
  logic [15:0] seen[$];
  logic [15:0] model_cnt = '0;
  logic [15:0] prev_cnt = '0;
  bit          wrapped = 1'b0;
  int          acc_a = 0, acc_b = 0;

  join_fflop #(.Size(8), .Depth(4)) dut (
    .clk(clk), .reset(reset),
    .inp_a(inp_a), .inp_aValid(inp_aValid), .inp_aRetry(inp_aRetry),
    .inp_b(inp_b), .inp_bValid(inp_bValid), .inp_bRetry(inp_bRetry),
    .out(out), .outValid(outValid), .outRetry(outRetry),
    .pair_count(pair_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Inputs are stable at the negedge, so what is seen here is what the next edge transfers.
  always @(negedge clk) begin
    logic [15:0] e;
    if (!reset) begin
      qa.delete(); qb.delete(); exp_q.delete();
      model_cnt = '0;
      prev_cnt  = '0;
      check("reset_outValid", 32'(outValid), 0);
      check("reset_pair_count", 32'(pair_count), 0);
      check("reset_out", 32'(out), 0);
      check("reset_retry", {30'd0, inp_aRetry, inp_bRetry}, 0);
    end else begin
      check("pair_count", 32'(pair_count), 32'(model_cnt));
      if (prev_cnt == 16'hFFFF && pair_count == 16'h0000) wrapped = 1'b1;
      prev_cnt = pair_count;
      if (outValid) begin
        if (exp_q.size() == 0) check("spurious_out", 1, 0);
        else if (!outRetry) begin
          e = exp_q.pop_front();
          check("out_data", 32'(out), 32'(e));
          seen.push_back(out);
          model_cnt = model_cnt + 16'd1;
        end
      end
      if (inp_aValid && !inp_aRetry) begin qa.push_back(inp_a); acc_a++; end
      if (inp_bValid && !inp_bRetry) begin qb.push_back(inp_b); acc_b++; end
      while (qa.size() != 0 && qb.size() != 0) exp_q.push_back({qa.pop_front(), qb.pop_front()});
    end
  end

  task automatic wait_idle(input int budget);
    int cyc = 0;
    while ((outValid || exp_q.size() != 0) && cyc < budget) begin step(); cyc++; end
    if (cyc >= budget) check("drain_timeout", 1, 0);
  endtask

  // Sends n tokens on each stream with random gaps, holding Valid/data while retried.
  task automatic stream(input int n, input int pct, input int rpct, input int budget);
    int sa = acc_a, sb = acc_b, pa = 0, pb = 0, cyc = 0;
    while ((acc_a - sa < n || acc_b - sb < n || inp_aValid || inp_bValid) && cyc < budget) begin
      if (!inp_aValid || acc_a != pa) begin
        inp_aValid = 1'b0;
        if (acc_a - sa < n && $urandom_range(99) < pct) begin
          inp_a = 8'($urandom); inp_aValid = 1'b1; pa = acc_a;
        end
      end
      if (!inp_bValid || acc_b != pb) begin
        inp_bValid = 1'b0;
        if (acc_b - sb < n && $urandom_range(99) < pct) begin
          inp_b = 8'($urandom); inp_bValid = 1'b1; pb = acc_b;
        end
      end
      outRetry = ($urandom_range(99) < rpct);
      step(); cyc++;
    end
    if (cyc >= budget) begin
      check("stream_timeout", 1, 0);
      $display("FAIL stream_timeout: stalled streaming; aborting");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "stream stalled");
    end
    outRetry = 1'b0;
  endtask

  initial begin
    int sa, sb, pa, pb, cyc;
    logic [15:0] sent[$];

    #2 reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      inp_a = 8'($urandom); inp_b = 8'($urandom);
      inp_aValid = 1'($urandom); inp_bValid = 1'($urandom); outRetry = 1'($urandom);
      step();
    end
    inp_aValid = 1'b0; inp_bValid = 1'b0; outRetry = 1'b0;
    reset = 1'b1;

    // First pair after reset: latency two edges.
    inp_a = 8'h11; inp_b = 8'h22; inp_aValid = 1'b1; inp_bValid = 1'b1;
    step();
    inp_aValid = 1'b0; inp_bValid = 1'b0;
    check("lat_valid_E0", 32'(outValid), 0);
    step();
    check("lat_valid_E1", 32'(outValid), 1);
    check("lat_out_E1", 32'(out), 32'h1122);
    wait_idle(20);

    // Skewed arrival: A fills its FIFO before any B shows up.
    seen.delete();
    for (int i = 1; i <= 4; i++) begin
      inp_a = 8'(i); inp_aValid = 1'b1;
      check("skew_aRetry", 32'(inp_aRetry), 0);
      step();
    end
    inp_aValid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      inp_b = 8'(8'hF0 + i); inp_bValid = 1'b1;
      step();
    end
    inp_bValid = 1'b0;
    wait_idle(20);
    check("skew_count", 32'(seen.size()), 4);
    for (int i = 0; i < 4 && i < seen.size(); i++)
      check("skew_seq", 32'(seen[i]), 32'({8'(i + 1), 8'(8'hF1 + i)}));

    // Back-pressure: output full, both FIFOs fill, then drain.
    seen.delete();
    outRetry = 1'b1;
    sa = acc_a; sb = acc_b;
    inp_a = 8'($urandom); inp_b = 8'($urandom); inp_aValid = 1'b1; inp_bValid = 1'b1;
    pa = acc_a; pb = acc_b; cyc = 0;
    while (!(inp_aRetry && inp_bRetry) && cyc < 20) begin
      step(); cyc++;
      if (acc_a != pa) begin inp_a = 8'($urandom); pa = acc_a; end
      if (acc_b != pb) begin inp_b = 8'($urandom); pb = acc_b; end
    end
    check("bp_both_retry", {30'd0, inp_aRetry, inp_bRetry}, 3);
    check("bp_acc_a", 32'(acc_a - sa), 6);
    check("bp_acc_b", 32'(acc_b - sb), 6);
    check("bp_outValid", 32'(outValid), 1);
    outRetry = 1'b0;
    cyc = 0;
    while ((inp_aValid || inp_bValid) && cyc < 20) begin
      step(); cyc++;
      if (acc_a != pa) inp_aValid = 1'b0;
      if (acc_b != pb) inp_bValid = 1'b0;
    end
    wait_idle(30);
    check("bp_total_out", 32'(seen.size()), 7);

    // Mid-run reset with three pairs buffered.
    outRetry = 1'b1;
    for (int i = 0; i < 3; i++) begin
      inp_a = 8'($urandom); inp_b = 8'($urandom); inp_aValid = 1'b1; inp_bValid = 1'b1;
      step();
    end
    inp_aValid = 1'b0; inp_bValid = 1'b0;
    step();
    check("mr_pre_outValid", 32'(outValid), 1);
    reset = 1'b0;
    #1;
    check("mr_outValid_now", 32'(outValid), 0);
    check("mr_pair_count_now", 32'(pair_count), 0);
    step(); step();
    reset = 1'b1;
    outRetry = 1'b0;
    seen.delete();
    for (int i = 0; i < 10; i++) step();
    check("mr_no_emit", 32'(seen.size()), 0);
    check("mr_outValid_after", 32'(outValid), 0);

    // Full throughput: 100 back-to-back pairs.
    seen.delete(); sent.delete();
    cyc = 0;
    for (int i = 0; i < 100; i++) begin
      inp_a = 8'($urandom); inp_b = 8'($urandom); inp_aValid = 1'b1; inp_bValid = 1'b1;
      sent.push_back({inp_a, inp_b});
      step(); cyc++;
    end
    inp_aValid = 1'b0; inp_bValid = 1'b0;
    while (seen.size() < 100 && cyc < 200) begin step(); cyc++; end
    check("tp_count", 32'(seen.size()), 100);
    check("tp_cycles_in_range", 32'(cyc >= 101 && cyc <= 103), 1);
    for (int i = 0; i < 100 && i < seen.size(); i++)
      if (seen[i] !== sent[i]) check("tp_order", 32'(seen[i]), 32'(sent[i]));
    check("tp_pair_count", 32'(pair_count), 100);

    // Random traffic with random back-pressure.
    stream(300, 70, 30, 5000);
    wait_idle(50);
    check("rand_pair_count", 32'(pair_count), 400);

    // Long run to carry pair_count through 0xFFFE -> 0xFFFF -> 0x0000.
    stream(65140, 100, 0, 70000);
    wait_idle(50);
    check("wrap_seen", 32'(wrapped), 1);
    check("wrap_pair_count", 32'(pair_count), 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/join_fflop.md
# join_fflop

Two-input join stage placed directly downstream of a `fork_fflop`, or of any pair of Valid/Retry producers. It accepts one token from each of two independent 8-bit streams and buffers each stream separately, so the two arrivals may be skewed in time. Once both heads are present it pairs them into one 16-bit token and drives that token through a registered two-entry output stage. Every output is a flop or is decoded from flops only, so no combinational path exists from any input to any output.

## Interface
Parameters:
- `Size`, default 8: width of each input token.
- `Depth`, default 4: entries per input FIFO. Must be a power of two and ≥2.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset asserted). Deassertion is synchronous to `clk` by the integrator.
- `inp_a`  in  Size  stream A data.
- `inp_aValid`  in  1  stream A token valid.
- `inp_aRetry`  out  1  stream A back-pressure.
- `inp_b`  in  Size  stream B data.
- `inp_bValid`  in  1  stream B token valid.
- `inp_bRetry`  out  1  stream B back-pressure.
- `out`  out  2*Size  joined token, `{A, B}` with A in the MSBs.
- `outValid`  out  1  joined token valid.
- `outRetry`  in  1  downstream back-pressure.
- `pair_count`  out  16  number of joined tokens accepted downstream; wraps modulo 2^16.

## Operation
- Transfer rule on every port: a token moves on a rising edge when Valid=1 and Retry=0. Valid is never withdrawn while Retry=1; a Valid held under Retry is not a transfer.
- Input FIFO X (X = a, b):
  - Pointers `wr_x` and `rd_x`, each log2(Depth) bits, plus occupancy `cnt_x`, 0..Depth.
  - Push when `inp_xValid & !inp_xRetry`.
  - `inp_xRetry = (cnt_x == Depth)`, decoded from the registered count only.
- Join fire condition: `cnt_a != 0 && cnt_b != 0 && occ < 2`. On fire, pop both heads on the same edge and write `{headA, headB}` into the output stage.
- Output stage: main register (drives `out`) plus one skid register, with occupancy `occ` 0..2.
  - `outValid = (occ != 0)`.
  - Pop when `outValid & !outRetry`. On pop, the skid entry moves into main.
  - Push and pop on the same edge: the pushed token lands in main if main empties and skid is empty; otherwise it lands in skid.
  - Order is strict FIFO.
- `pair_count` increments by 1 on each output pop and wraps from 0xFFFF to 0x0000.
- Unequal token counts on A and B: the surplus stays buffered. That input stalls via Retry once its FIFO is full. It is never dropped or realigned.

## Timing
- Reset values, applied asynchronously while `reset`=0: every count and pointer is 0, `outValid`=0, `out`=0, `inp_aRetry`=0, `inp_bRetry`=0, `pair_count`=0. Data RAM contents are don't-care.
- Reset asserted mid-operation discards all buffered tokens immediately. No transfer completes on an edge during which `reset`=0.
- Latency: A and B both pushed on edge E0 → fire on edge E0+1 → `outValid`=1 in the cycle after E0+1.
- Skewed arrival, A at E0 and B at Ek (k>0): `outValid` rises after edge Ek+1.
- Throughput: one joined token per cycle in steady state when `outRetry`=0 and both inputs stream continuously.
- Boundaries:
  - FIFO full with push attempted: Retry=1, so no push.
  - Pop and push on the same edge while full: allowed from the Retry=0 state only. `cnt` stays the same.
  - Pointer wrap from Depth-1 to 0 is seamless.
  - `occ`=2 with `outRetry`=1: no fire, and input FIFOs fill.
  - Empty FIFO never pops.

## Test plan
- Reset: hold `reset`=0 while driving random stimulus, then release. Required: all outputs at reset values; the first pair A=0x11 at E0, B=0x22 at E0 yields `out`=0x1122 with `outValid` rising after edge E0+1.
- Skew: send 4 A tokens 0x01..0x04 with B idle, then send B tokens 0xF1..0xF4. Required: `inp_aRetry` stays 0 with Depth=4; `out` sequence is 0x01F1, 0x02F2, 0x03F3, 0x04F4.
- Back-pressure: hold `outRetry`=1, stream A and B continuously. Required: `occ` reaches 2; `inp_aRetry`=`inp_bRetry`=1 after 4 more pairs (Depth=4); no token lost or duplicated once `outRetry` drops.
- Full throughput: 100 pairs with `outRetry`=0. Required: 100 outputs in 101–103 cycles, in order; `pair_count`=100.
- Wrap: preload `pair_count` near 0xFFFE via a long run. Required: 0xFFFE → 0xFFFF → 0x0000. Input pointers also wrap past Depth-1 cleanly, with data order preserved.
- Mid-run reset: assert `reset` with 3 tokens buffered. Required: `outValid`=0 immediately, the tokens are not emitted after release, and `pair_count`=0.
